// File: rtl/button_input_conditioner.sv
// Button input conditioner: four raw push-buttons are synchronized and
// debounced, and a two-state press FSM reports a single accepted press
// (key_valid with key_code) or a rejected multi-button press (key_error).
module button_input_conditioner #(
    parameter int DEBOUNCE_COUNT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    output logic [1:0] key_code,
    output logic       key_valid,
    output logic       key_error,
    output logic       any_held
);

    localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
    // Counter value in the cycle before it would reach DEBOUNCE_COUNT.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // Bit index equals the button's key code: U=0, D=1, L=2, R=3.
    logic [3:0]    raw_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    deb_r;
    logic [CW-1:0] cnt_r [0:3];
    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic [1:0]    code_nxt_s;
    logic          valid_nxt_s;
    logic          error_nxt_s;
    logic [2:0]    num_high_s;

    // Number of debounced levels currently high.
    function automatic logic [2:0] count_high(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Key code of the single high level in a one-hot vector.
    function automatic logic [1:0] encode_one(input logic [3:0] v);
        logic [1:0] c;
        case (v)
            4'b0001: c = 2'b00;
            4'b0010: c = 2'b01;
            4'b0100: c = 2'b10;
            4'b1000: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    assign raw_s      = {btnR, btnL, btnD, btnU};
    assign num_high_s = count_high(deb_r);
    assign any_held   = |deb_r;

    // Two-flop synchronizer; the only consumer of the raw button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: count consecutive mismatching cycles, toggle on the Nth.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == CNT_LAST) begin
                        deb_r[i] <= ~deb_r[i];
                        cnt_r[i] <= CNT_ZERO;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    end
                end else begin
                    cnt_r[i] <= CNT_ZERO;
                end
            end
        end
    end

    // Press FSM next state: accept one button, reject several, wait for all released.
    always_comb begin
        state_nxt_s = state_r;
        code_nxt_s  = key_code;
        valid_nxt_s = 1'b0;
        error_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (num_high_s == 3'd1) begin
                    valid_nxt_s = 1'b1;
                    code_nxt_s  = encode_one(deb_r);
                    state_nxt_s = ST_HELD;
                end else if (num_high_s >= 3'd2) begin
                    error_nxt_s = 1'b1;
                    state_nxt_s = ST_HELD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (deb_r == 4'b0000) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered press outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            key_code  <= 2'b00;
            key_valid <= 1'b0;
            key_error <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            key_code  <= code_nxt_s;
            key_valid <= valid_nxt_s;
            key_error <= error_nxt_s;
        end
    end

endmodule
